// File: rtl/icache_dataram_port_sched.sv
// Single-port icache data-array scheduler: line-granular arbitration between
// MSHR line reads and downstream linefill beats, with read starvation relief.
module icache_dataram_port_sched #(
  parameter int WAY_NUM    = 2,
  parameter int INDEX_W    = 7,
  parameter int TXNID_W    = 5,
  parameter int ENTRY_W    = 3,
  parameter int DATA_W     = 128,
  parameter int BEATS      = 4,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 8,
  localparam int WAY_W     = (WAY_NUM > 1) ? $clog2(WAY_NUM) : 1,
  localparam int BEAT_W    = $clog2(BEATS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rd_vld,
  output logic               rd_rdy,
  input  logic [WAY_W-1:0]   rd_way,
  input  logic [INDEX_W-1:0] rd_index,
  input  logic [TXNID_W-1:0] rd_txnid,
  input  logic               fill_vld,
  output logic               fill_rdy,
  input  logic [WAY_W-1:0]   fill_way,
  input  logic [INDEX_W-1:0] fill_index,
  input  logic [ENTRY_W-1:0] fill_entry_id,
  input  logic [DATA_W-1:0]  fill_data,
  input  logic               fill_last,
  output logic               ram_en,
  output logic               ram_wr,
  output logic [WAY_W-1:0]   ram_way,
  output logic [INDEX_W-1:0] ram_index,
  output logic [BEAT_W-1:0]  ram_beat,
  output logic [DATA_W-1:0]  ram_wdata,
  output logic               rd_resp_vld,
  output logic [TXNID_W-1:0] rd_resp_txnid,
  output logic               rd_resp_last,
  output logic               linefill_done,
  output logic [ENTRY_W-1:0] linefill_done_idx,
  output logic               fill_err
);

  localparam int SC_W = $clog2(STARVE_MAX + 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(BEATS - 1);
  localparam logic [SC_W-1:0]   STARVE_SAT = SC_W'(STARVE_MAX);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_FILL
  } state_t;

  state_t             state, state_nxt;
  logic [BEAT_W-1:0]  beat_cnt, beat_nxt;
  logic [SC_W-1:0]    starve_cnt;

  logic [WAY_W-1:0]   lat_way;
  logic [INDEX_W-1:0] lat_index;
  logic [TXNID_W-1:0] lat_txnid;
  logic [ENTRY_W-1:0] lat_entry;

  logic               fill_win;
  logic               rd_take;
  logic               fill_take;
  logic               fill_end;
  logic               fill_bad;
  logic               rd_issue;
  logic [ENTRY_W-1:0] done_entry;

  logic               done_q;
  logic [ENTRY_W-1:0] done_idx_q;
  logic               err_q;

  logic               pipe_vld   [RD_LAT];
  logic [TXNID_W-1:0] pipe_txnid [RD_LAT];
  logic               pipe_last  [RD_LAT];

  always_comb begin
    state_nxt  = state;
    beat_nxt   = beat_cnt;
    rd_rdy     = 1'b0;
    fill_rdy   = 1'b0;
    ram_en     = 1'b0;
    ram_wr     = 1'b0;
    ram_way    = '0;
    ram_index  = '0;
    ram_beat   = '0;
    ram_wdata  = '0;
    fill_win   = 1'b0;
    rd_take    = 1'b0;
    fill_take  = 1'b0;
    fill_end   = 1'b0;
    fill_bad   = 1'b0;
    rd_issue   = 1'b0;
    done_entry = lat_entry;
    if (!rst) begin
      case (state)
        S_IDLE: begin
          fill_win = fill_vld & ~(rd_vld & (starve_cnt == STARVE_SAT));
          if (fill_win) begin
            fill_rdy  = 1'b1;
            fill_take = 1'b1;
            ram_en    = 1'b1;
            ram_wr    = 1'b1;
            ram_way   = fill_way;
            ram_index = fill_index;
            ram_wdata = fill_data;
            // Beat 0 can never be the final beat, so a last here is a protocol error
            fill_bad  = fill_last;
            if (fill_last) begin
              fill_end   = 1'b1;
              done_entry = fill_entry_id;
            end else begin
              state_nxt = S_FILL;
              beat_nxt  = BEAT_W'(1);
            end
          end else if (rd_vld) begin
            rd_rdy    = 1'b1;
            rd_take   = 1'b1;
            state_nxt = S_READ;
            beat_nxt  = '0;
          end
        end
        S_FILL: begin
          fill_rdy = 1'b1;
          if (fill_vld) begin
            fill_take = 1'b1;
            ram_en    = 1'b1;
            ram_wr    = 1'b1;
            ram_way   = lat_way;
            ram_index = lat_index;
            ram_beat  = beat_cnt;
            ram_wdata = fill_data;
            fill_bad  = fill_last != (beat_cnt == LAST_BEAT);
            if (fill_last) begin
              fill_end  = 1'b1;
              state_nxt = S_IDLE;
              beat_nxt  = '0;
            end else begin
              beat_nxt = beat_cnt + 1'b1;
            end
          end
        end
        S_READ: begin
          rd_issue  = 1'b1;
          ram_en    = 1'b1;
          ram_way   = lat_way;
          ram_index = lat_index;
          ram_beat  = beat_cnt;
          if (beat_cnt == LAST_BEAT) begin
            state_nxt = S_IDLE;
            beat_nxt  = '0;
          end else begin
            beat_nxt = beat_cnt + 1'b1;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      beat_cnt   <= '0;
      starve_cnt <= '0;
      lat_way    <= '0;
      lat_index  <= '0;
      lat_txnid  <= '0;
      lat_entry  <= '0;
      done_q     <= 1'b0;
      done_idx_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state    <= state_nxt;
      beat_cnt <= beat_nxt;
      if (rd_take || !rd_vld) begin
        starve_cnt <= '0;
      end else if (starve_cnt != STARVE_SAT) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
      if (rd_take) begin
        lat_way   <= rd_way;
        lat_index <= rd_index;
        lat_txnid <= rd_txnid;
      end
      if (fill_take && state == S_IDLE) begin
        lat_way   <= fill_way;
        lat_index <= fill_index;
        lat_entry <= fill_entry_id;
      end
      done_q     <= fill_end;
      done_idx_q <= fill_end ? done_entry : '0;
      if (fill_bad) begin
        err_q <= 1'b1;
      end
    end
  end

  // Response shift line runs independently of the FSM so it can overlap a following fill
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < RD_LAT; i++) begin
        pipe_vld[i]   <= 1'b0;
        pipe_txnid[i] <= '0;
        pipe_last[i]  <= 1'b0;
      end
    end else begin
      pipe_vld[0]   <= rd_issue;
      pipe_txnid[0] <= rd_issue ? lat_txnid : '0;
      pipe_last[0]  <= rd_issue & (beat_cnt == LAST_BEAT);
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        pipe_vld[i]   <= pipe_vld[i-1];
        pipe_txnid[i] <= pipe_txnid[i-1];
        pipe_last[i]  <= pipe_last[i-1];
      end
    end
  end

  assign rd_resp_vld       = pipe_vld[RD_LAT-1] & ~rst;
  assign rd_resp_txnid     = pipe_txnid[RD_LAT-1] & {TXNID_W{~rst}};
  assign rd_resp_last      = pipe_last[RD_LAT-1] & ~rst;
  assign linefill_done     = done_q & ~rst;
  assign linefill_done_idx = done_idx_q & {ENTRY_W{~rst}};
  assign fill_err          = err_q & ~rst;

endmodule

// File: doc/icache_dataram_port_sched.md
Name: icache_dataram_port_sched

Overview:
- Schedules the single icache data-array port between two requesters: line-read requests from the MSHR file for hits and replays, and linefill beats arriving on downstream rxdat.
- Arbitration is at cache-line granularity. A granted read or fill owns the port until all of its beats complete.
- Linefill has priority over reads. A saturating starvation counter guarantees reads are eventually granted.
- Sits between icache_mshr_file / downstream rxdat and the data-array macro. Emits read-beat responses and a linefill-done pulse back to the MSHR.

Parameters:
WAY_NUM, 2, ways per set; way field width WAY_W = clog2(WAY_NUM)
INDEX_W, 7, set index width
TXNID_W, 5, read transaction id width
ENTRY_W, 3, MSHR entry index width
DATA_W, 128, data width per beat
BEATS, 4, beats per cache line; power of 2, >=2; BEAT_W = clog2(BEATS)
RD_LAT, 1, data-array read latency in cycles (>=1)
STARVE_MAX, 8, number of lost-arbitration cycles after which a read wins

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
rd_vld  in  1  line-read request valid
rd_rdy  out  1  line-read request accepted
rd_way  in  WAY_W  way to read
rd_index  in  INDEX_W  set to read
rd_txnid  in  TXNID_W  id returned with every response beat
fill_vld  in  1  linefill beat valid
fill_rdy  out  1  linefill beat accepted
fill_way  in  WAY_W  victim way; sampled on the first beat only
fill_index  in  INDEX_W  set; sampled on the first beat only
fill_entry_id  in  ENTRY_W  owning MSHR entry; sampled on the first beat only
fill_data  in  DATA_W  beat data
fill_last  in  1  final beat of the line
ram_en  out  1  data-array access this cycle
ram_wr  out  1  1 = write, 0 = read
ram_way  out  WAY_W  data-array way
ram_index  out  INDEX_W  data-array set
ram_beat  out  BEAT_W  beat within the line
ram_wdata  out  DATA_W  write data
rd_resp_vld  out  1  read data from the array is valid (data itself taken from the macro)
rd_resp_txnid  out  TXNID_W  id of the response beat
rd_resp_last  out  1  final beat of a read line
linefill_done  out  1  one-cycle pulse: line fully written
linefill_done_idx  out  ENTRY_W  MSHR entry whose linefill completed
fill_err  out  1  sticky protocol error flag

Behaviour:
- States: IDLE, READ, FILL.
- Reset: all outputs are 0, state = IDLE, beat counter = 0, starve_cnt = 0, the response shift pipeline is flushed.
- Reset mid-operation abandons the line in progress. No linefill_done and no further rd_resp_vld are produced for it.
- All ram_* outputs are 0 whenever ram_en = 0.

IDLE arbitration:
- fill_win = fill_vld & ~(rd_vld & starve_cnt == STARVE_MAX).
- rd_win = rd_vld & ~fill_win.
- fill_rdy = fill_win; rd_rdy = rd_win.

Fill path:
- On a fill handshake in IDLE, beat 0 is written in the same cycle: ram_en = 1, ram_wr = 1, ram_beat = 0, ram_wdata = fill_data.
- way/index/entry_id are latched and the state moves to FILL.
- In FILL: fill_rdy = 1. Each handshake writes the next beat (combinational pass-through) and increments the beat counter.
- A cycle with fill_vld = 0 leaves the port idle; the state stays FILL and reads remain blocked.
- The line ends on the handshake carrying fill_last. The state returns to IDLE, and the next cycle pulses linefill_done with the latched entry_id.
- If fill_last arrives with beat != BEATS-1, or beat BEATS-1 arrives without fill_last:
  - fill_err is set (sticky until rst);
  - the line still terminates on fill_last;
  - if fill_last is missing, the counter wraps.

Read path:
- On a read handshake, way/index/txnid are latched, starve_cnt is cleared, and the state moves to READ.
- READ issues exactly BEATS consecutive read cycles: ram_en = 1, ram_wr = 0, ram_beat = 0..BEATS-1. Beat 0 is issued the cycle after acceptance.
- After the last read beat the state returns to IDLE. rd_rdy and fill_rdy are 0 throughout READ.
- Each read beat produces rd_resp_vld exactly RD_LAT cycles after its ram_en, with the latched txnid. rd_resp_last accompanies beat BEATS-1.
- Response cycles may overlap a following fill; the response pipeline is independent of the state.

Starvation:
- starve_cnt increments, saturating at STARVE_MAX, on every cycle with rd_vld = 1 and no read handshake.
- starve_cnt is cleared on a read handshake, or when rd_vld = 0.

Simultaneous and boundary events:
- A new request is never accepted in the last beat cycle of READ or FILL. The earliest next grant is the following IDLE cycle.
- Back-to-back lines therefore have exactly one IDLE cycle between them.
- linefill_done may coincide with the first beat of a new grant.

Test Plan:
- Single fill: BEATS = 4, fill_vld held high, way = 1, index = 0x15, entry = 3 -> ram_en/ram_wr high for 4 cycles with ram_beat 0,1,2,3 -> linefill_done = 1, idx = 3 the cycle after the last beat -> fill_err = 0.
- Single read: way = 0, index = 0x2A, txnid = 9 -> ram_en reads on cycles +1..+4 -> rd_resp_vld on cycles +2..+5, txnid = 9 -> rd_resp_last on cycle +5.
- Contention: rd_vld and fill_vld both high from the same cycle, fills continuously available -> fills win until starve_cnt reaches 8 -> the next IDLE grants the read; starve_cnt returns to 0 on that grant.
- Gapped fill: fill_vld toggled 1,0,1,0,... -> 4 writes spread over 7 cycles -> rd_rdy stays 0 throughout despite rd_vld = 1.
- Protocol error: fill_last on beat 2 -> fill_err = 1 and linefill_done still pulses -> fill_err stays 1 through a subsequent clean fill -> clears only on rst.
- Mid-operation reset: rst asserted during READ beat 1 -> next cycle state IDLE, all outputs 0 -> no rd_resp_vld follows for the abandoned beats.
